// File: rtl/div_pkg.sv
// Shared divider definitions: FSM state encodings and the ALU op codes
// that the EX stage decodes into start/signed_div.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
  localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;

  // EX glue helpers: which ALU ops need the divider, and which are signed.
  function automatic logic div_is_op(input logic [7:0] aluop);
    return (aluop == DIV_CONTROL) || (aluop == DIVU_CONTROL);
  endfunction

  function automatic logic div_is_signed(input logic [7:0] aluop);
    return aluop == DIV_CONTROL;
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// result = {remainder, quotient}; ready holds while start stays high.
module div
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               annul,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dividend_r;   // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] rem_r;        // partial remainder
  logic [WIDTH-1:0] divisor_r;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   trial_rem;
  logic [WIDTH:0]   trial_diff;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes, one trial subtraction, and final sign fix-up.
  always_comb begin
    a_abs      = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    b_abs      = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    trial_rem  = {rem_r, dividend_r[WIDTH-1]};
    trial_diff = trial_rem - {1'b0, divisor_r};
    quo_fix    = q_neg ? -dividend_r : dividend_r;
    rem_fix    = r_neg ? -rem_r : rem_r;
  end

  assign stall_req = start & ~ready & ~annul;

  // Divider FSM and datapath; annul abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DIV_FREE;
      cnt        <= '0;
      dividend_r <= '0;
      rem_r      <= '0;
      divisor_r  <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      result     <= '0;
      ready      <= 1'b0;
    end else if (annul && state != DIV_FREE) begin
      state  <= DIV_FREE;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready  <= 1'b0;
          result <= '0;
          if (start && !annul) begin
            dividend_r <= a_abs;
            divisor_r  <= b_abs;
            rem_r      <= '0;
            cnt        <= '0;
            q_neg      <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            r_neg      <= signed_div & opdata1[WIDTH-1];
            state      <= (opdata2 == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          result <= '0;
          state  <= DIV_END;
        end
        DIV_ON: begin
          if (cnt == CNT_W'(WIDTH)) begin
            result <= {rem_fix, quo_fix};
            ready  <= 1'b1;
            state  <= DIV_END;
          end else begin
            // trial_rem < 2*divisor, so a clear top bit of the difference
            // means the subtraction succeeded and fits in WIDTH bits.
            if (!trial_diff[WIDTH]) begin
              rem_r      <= trial_diff[WIDTH-1:0];
              dividend_r <= {dividend_r[WIDTH-2:0], 1'b1};
            end else begin
              rem_r      <= trial_rem[WIDTH-1:0];
              dividend_r <= {dividend_r[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
        end
        DIV_END: begin
          if (!start) begin
            state  <= DIV_FREE;
            ready  <= 1'b0;
            result <= '0;
          end else begin
            ready <= 1'b1;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the restoring divider: directed table,
// multi-cycle corner sequences, and randomized operations vs. a model.
module tb_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  int n_cmp = 0;
  int n_bad = 0;

  div #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .annul     (annul),
    .signed_div(signed_div),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .result    (result),
    .ready     (ready),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [31:0] q;
    logic [31:0] r;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division (truncating toward zero), 0/0 for divide by zero.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called just after a negedge. Issues an op, waits for ready, checks
  // latency via stall count, holds start for 'hold' cycles, then releases.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic [31:0] eq, input logic [31:0] er, input int hold,
                        input bit scramble, input string nm);
    int   stalls;
    bit   got;
    int   exp_stalls;
    exp_stalls = (b == 32'h0) ? 3 : 34;
    opdata1 = a; opdata2 = b; signed_div = sg; start = 1'b1; annul = 1'b0;
    stalls = 0; got = 1'b0;
    for (int w = 0; w < 100 && !got; w++) begin
      #1;
      if (stall_req) stalls++;
      if (ready) got = 1'b1;
      else begin
        @(negedge clk);
        if (scramble) begin
          opdata1 = $urandom; opdata2 = $urandom; signed_div = ~signed_div;
        end
      end
    end
    chk({nm, "_ready_seen"}, 64'(got), 64'd1);
    chk({nm, "_stall_cycles"}, 64'(stalls), 64'(exp_stalls));
    chk({nm, "_result"}, result, {er, eq});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      chk({nm, "_hold_ready"}, 64'(ready), 64'd1);
      chk({nm, "_hold_result"}, result, {er, eq});
    end
    @(negedge clk);
    start = 1'b0; opdata1 = '0; opdata2 = '0; signed_div = 1'b0;
    #1;
    chk({nm, "_release_stall"}, 64'(stall_req), 64'd0);
    @(negedge clk); #1;
    chk({nm, "_clear_ready"}, 64'(ready), 64'd0);
    chk({nm, "_clear_result"}, result, 64'h0);
  endtask

  // Issue DIVU 100/7, interrupt at edge 10 with annul or rst, recover with 9/3.
  task automatic abort_seq(input bit use_rst, input string nm);
    bit saw_ready;
    saw_ready = 1'b0;
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1; annul = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk); #1;
      if (ready) saw_ready = 1'b1;
    end
    if (use_rst) rst = 1'b1;
    else begin
      annul = 1'b1;
      #1;
      chk({nm, "_annul_stall"}, 64'(stall_req), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0; annul = 1'b0;
    #1;
    if (ready) saw_ready = 1'b1;
    chk({nm, "_no_ready"}, 64'(saw_ready), 64'd0);
    chk({nm, "_result_zero"}, result, 64'h0);
    run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1, 1'b0, {nm, "_recover"});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] m;

    vecs[0] = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1};
    vecs[1] = '{32'hFFFFFFF9, 32'h2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1};
    vecs[2] = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h00000001, 1};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0,        1};
    vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h80000000, 1};
    vecs[5] = '{32'd5,        32'd0,        1'b0, 32'h0,        32'h0,        3};
    vecs[6] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'h0,        0};
    vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd1,        32'h0,        2};

    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'h0);
    chk("reset_stall", 64'(stall_req), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // start together with annul in FREE must be ignored
    start = 1'b1; annul = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
    #1;
    chk("annul_free_stall", 64'(stall_req), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("annul_free_ready", 64'(ready), 64'd0);
    start = 1'b0; annul = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].q, vecs[i].r, vecs[i].hold,
             1'b0, $sformatf("vec%0d", i));

    abort_seq(1'b0, "annul_seq");
    abort_seq(1'b1, "rst_seq");

    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1, 1'b1, "scramble_divu");
    run_op(32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1, 1'b1, "scramble_div");

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      m = model(ra, rb, rs);
      run_op(ra, rb, rs, m[31:0], m[63:32], $urandom_range(0, 2), 1'($urandom_range(0, 1)),
             $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
